// File: rtl/axi_sram_bank_array.sv
// Banked SRAM array behind the AXI SRAM wrapper. Each bank has a
// byte-maskable array, a fixed-latency read pipeline and a held read
// register. Also flags multiple rows selected in one column and keeps
// saturating read/write cycle counters.
module axi_sram_bank_array #(
  parameter int SRAM_BANKS_ROWS      = 1,
  parameter int SRAM_BANKS_COLS      = 1,
  parameter int SRAM_BANK_ADDR_WIDTH = 16,
  parameter int SRAM_BANK_DATA_WIDTH = 32,
  parameter int SRAM_READ_LATENCY    = 2,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                                                                  clk_i,
  input  logic                                                                  rst_i,
  input  logic [SRAM_BANK_ADDR_WIDTH-1:0]                                       bank_addr,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                       bank_cs,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0]                       bank_we,
  input  logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH/8-1:0] bank_be,
  input  logic [SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0]                  bank_wdata,
  output logic [SRAM_BANKS_ROWS-1:0][SRAM_BANKS_COLS-1:0][SRAM_BANK_DATA_WIDTH-1:0] bank_rdata,
  output logic                                                                  err_multi_row_o,
  output logic [CNT_WIDTH-1:0]                                                  rd_cnt_o,
  output logic [CNT_WIDTH-1:0]                                                  wr_cnt_o,
  input  logic                                                                  cnt_clr_i
);

  localparam int ROWS  = SRAM_BANKS_ROWS;
  localparam int COLS  = SRAM_BANKS_COLS;
  localparam int DW    = SRAM_BANK_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int LAT   = SRAM_READ_LATENCY;
  localparam int DEPTH = 1 << SRAM_BANK_ADDR_WIDTH;

  // Banks reading (cs without we) and writing (cs with we) at this edge.
  logic [ROWS-1:0][COLS-1:0] rd_sel;
  logic [ROWS-1:0][COLS-1:0] wr_sel;

  assign rd_sel = bank_cs & ~bank_we;
  assign wr_sel = bank_cs & bank_we;

  logic                 multi_row;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;

  // Next state of the sticky multi-row flag and the saturating cycle counters.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    multi_row = 1'b0;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    for (int c = 0; c < COLS; c++) begin
      for (int r1 = 0; r1 < ROWS; r1++) begin
        for (int r2 = r1 + 1; r2 < ROWS; r2++) begin
          multi_row = multi_row | (bank_cs[r1][c] & bank_cs[r2][c]);
        end
      end
    end
    err_d = err_q | multi_row;
    if (cnt_clr_i) begin
      rd_cnt_d = '0;
      wr_cnt_d = '0;
    end else begin
      if ((|rd_sel) && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
      if ((|wr_sel) && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Status and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign err_multi_row_o = err_q;
  assign rd_cnt_o        = rd_cnt_q;
  assign wr_cnt_o        = wr_cnt_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [DW-1:0] mem_q [DEPTH];
      logic [DW-1:0] rd_word;
      logic          tail_vld;
      logic [DW-1:0] tail_data;
      logic [DW-1:0] rdata_q, rdata_d;

      // Byte-masked write into this bank's array.
      // NOTE: the array has no reset; contents survive rst_i and a reset port would block RAM mapping.
      always_ff @(posedge clk_i) begin
        if (wr_sel[r][c]) begin
          for (int b = 0; b < NB; b++) begin
            if (bank_be[r][c][b]) mem_q[bank_addr][b*8 +: 8] <= bank_wdata[c][b*8 +: 8];
          end
        end
      end

      assign rd_word = mem_q[bank_addr];

      if (LAT == 1) begin : g_direct
        // The read register itself is the only stage.
        assign tail_vld  = rd_sel[r][c];
        assign tail_data = rd_word;
      end else begin : g_pipe
        logic [LAT-2:0]         vld_q, vld_d;
        logic [LAT-2:0][DW-1:0] data_q, data_d;

        // Advance in-flight reads one stage per cycle; stage 0 captures the array word.
        always_comb begin
          vld_d     = vld_q;
          data_d    = data_q;
          vld_d[0]  = rd_sel[r][c];
          data_d[0] = rd_word;
          for (int i = 1; i < LAT - 1; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
          end
        end

        // Pipeline registers; clearing the valid bits drops reads in flight.
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            vld_q  <= '0;
            data_q <= '0;
          end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
          end
        end

        assign tail_vld  = vld_q[LAT-2];
        assign tail_data = data_q[LAT-2];
      end

      // Load read data when a valid read completes, otherwise hold.
      always_comb begin
        rdata_d = rdata_q;
        if (tail_vld) rdata_d = tail_data;
      end

      // Per-bank read data register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_q <= '0;
        else       rdata_q <= rdata_d;
      end

      assign bank_rdata[r][c] = rdata_q;
    end
  end

endmodule

// File: tb/tb_axi_sram_bank_array.sv
// Self-checking bench: directed cases on three configurations
// (2x2 latency 2, 1x1 latency 3, 1x1 latency 1 with 16-bit words) and a
// randomized run on the 2x2 instance against an array/queue reference model.
module tb_axi_sram_bank_array;

  localparam int A_R = 2, A_C = 2, A_AW = 8, A_DW = 32, A_LAT = 2, A_CW = 4;
  localparam int B_AW = 16, B_DW = 32, B_LAT = 3, B_CW = 32;
  localparam int C_AW = 4, C_DW = 16, C_LAT = 1, C_CW = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  // Instance A
  logic [A_AW-1:0]                         a_addr  = '0;
  logic [A_R-1:0][A_C-1:0]                 a_cs    = '0;
  logic [A_R-1:0][A_C-1:0]                 a_we    = '0;
  logic [A_R-1:0][A_C-1:0][A_DW/8-1:0]     a_be    = '0;
  logic [A_C-1:0][A_DW-1:0]                a_wdata = '0;
  logic [A_R-1:0][A_C-1:0][A_DW-1:0]       a_rdata;
  logic                                    a_err;
  logic [A_CW-1:0]                         a_rd_cnt, a_wr_cnt;
  logic                                    a_clr   = 1'b0;

  // Instance B
  logic [B_AW-1:0]         b_addr  = '0;
  logic [0:0][0:0]         b_cs    = '0;
  logic [0:0][0:0]         b_we    = '0;
  logic [0:0][0:0][3:0]    b_be    = '0;
  logic [0:0][B_DW-1:0]    b_wdata = '0;
  logic [0:0][0:0][B_DW-1:0] b_rdata;
  logic                    b_err;
  logic [B_CW-1:0]         b_rd_cnt, b_wr_cnt;

  // Instance C
  logic [C_AW-1:0]         c_addr  = '0;
  logic [0:0][0:0]         c_cs    = '0;
  logic [0:0][0:0]         c_we    = '0;
  logic [0:0][0:0][1:0]    c_be    = '0;
  logic [0:0][C_DW-1:0]    c_wdata = '0;
  logic [0:0][0:0][C_DW-1:0] c_rdata;
  logic                    c_err;
  logic [C_CW-1:0]         c_rd_cnt, c_wr_cnt;

  axi_sram_bank_array #(
    .SRAM_BANKS_ROWS(A_R), .SRAM_BANKS_COLS(A_C), .SRAM_BANK_ADDR_WIDTH(A_AW),
    .SRAM_BANK_DATA_WIDTH(A_DW), .SRAM_READ_LATENCY(A_LAT), .CNT_WIDTH(A_CW)
  ) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .bank_addr(a_addr), .bank_cs(a_cs), .bank_we(a_we),
    .bank_be(a_be), .bank_wdata(a_wdata), .bank_rdata(a_rdata), .err_multi_row_o(a_err),
    .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt), .cnt_clr_i(a_clr)
  );

  axi_sram_bank_array #(
    .SRAM_BANKS_ROWS(1), .SRAM_BANKS_COLS(1), .SRAM_BANK_ADDR_WIDTH(B_AW),
    .SRAM_BANK_DATA_WIDTH(B_DW), .SRAM_READ_LATENCY(B_LAT), .CNT_WIDTH(B_CW)
  ) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .bank_addr(b_addr), .bank_cs(b_cs), .bank_we(b_we),
    .bank_be(b_be), .bank_wdata(b_wdata), .bank_rdata(b_rdata), .err_multi_row_o(b_err),
    .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt), .cnt_clr_i(1'b0)
  );

  axi_sram_bank_array #(
    .SRAM_BANKS_ROWS(1), .SRAM_BANKS_COLS(1), .SRAM_BANK_ADDR_WIDTH(C_AW),
    .SRAM_BANK_DATA_WIDTH(C_DW), .SRAM_READ_LATENCY(C_LAT), .CNT_WIDTH(C_CW)
  ) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .bank_addr(c_addr), .bank_cs(c_cs), .bank_we(c_we),
    .bank_be(c_be), .bank_wdata(c_wdata), .bank_rdata(c_rdata), .err_multi_row_o(c_err),
    .rd_cnt_o(c_rd_cnt), .wr_cnt_o(c_wr_cnt), .cnt_clr_i(1'b0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic a_idle();
    a_cs  = '0;
    a_we  = '0;
    a_be  = '0;
    a_clr = 1'b0;
  endtask

  // Reference model for instance A in the random phase.
  typedef struct {
    int          due;
    int          r;
    int          c;
    logic [31:0] d;
  } pend_t;

  logic [31:0] m_mem   [A_R][A_C][16];
  logic [31:0] m_rdata [A_R][A_C];
  logic        m_err;
  int          m_rd, m_wr;
  pend_t       pend[$];

  task automatic run_random(input int n_cycles);
    int    cyc;
    int    idx;
    int    rows_hit;
    bit    any_rd, any_wr;
    pend_t p;
    for (int r = 0; r < A_R; r++)
      for (int c = 0; c < A_C; c++) m_rdata[r][c] = '0;
    m_err = 1'b0;
    m_rd  = 0;
    m_wr  = 0;
    cyc   = 0;
    for (int n = 0; n < n_cycles; n++) begin
      // Stimulus: the first 16 cycles fill every bank at 0x80..0x8F.
      idx    = (n < 16) ? n : int'($urandom_range(0, 15));
      a_addr = A_AW'(8'h80 + idx);
      a_clr  = (n >= 16) && ($urandom_range(0, 15) == 0);
      for (int c = 0; c < A_C; c++) a_wdata[c] = $urandom;
      for (int r = 0; r < A_R; r++) begin
        for (int c = 0; c < A_C; c++) begin
          a_cs[r][c] = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
          a_we[r][c] = (n < 16) ? 1'b1 : 1'($urandom_range(0, 1));
          a_be[r][c] = (n < 16) ? 4'hF : 4'($urandom_range(0, 15));
        end
      end
      // Model the edge: reads capture the old word, writes merge enabled bytes.
      any_rd = 1'b0;
      any_wr = 1'b0;
      for (int r = 0; r < A_R; r++) begin
        for (int c = 0; c < A_C; c++) begin
          if (a_cs[r][c] && !a_we[r][c]) begin
            any_rd = 1'b1;
            p.due  = cyc + A_LAT - 1;
            p.r    = r;
            p.c    = c;
            p.d    = m_mem[r][c][idx];
            pend.push_back(p);
          end else if (a_cs[r][c] && a_we[r][c]) begin
            any_wr = 1'b1;
            for (int b = 0; b < 4; b++)
              if (a_be[r][c][b]) m_mem[r][c][idx][b*8 +: 8] = a_wdata[c][b*8 +: 8];
          end
        end
      end
      for (int c = 0; c < A_C; c++) begin
        rows_hit = 0;
        for (int r = 0; r < A_R; r++) rows_hit += int'(a_cs[r][c]);
        if (rows_hit >= 2) m_err = 1'b1;
      end
      if (a_clr) begin
        m_rd = 0;
        m_wr = 0;
      end else begin
        if (any_rd && m_rd < 15) m_rd++;
        if (any_wr && m_wr < 15) m_wr++;
      end
      tick();
      while (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        m_rdata[p.r][p.c] = p.d;
      end
      cyc++;
      for (int r = 0; r < A_R; r++)
        for (int c = 0; c < A_C; c++)
          check("rnd_rdata", 64'(a_rdata[r][c]), 64'(m_rdata[r][c]));
      check("rnd_err", 64'(a_err), 64'(m_err));
      check("rnd_rd_cnt", 64'(a_rd_cnt), 64'(m_rd));
      check("rnd_wr_cnt", 64'(a_wr_cnt), 64'(m_wr));
    end
    a_idle();
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick();
    tick();
    for (int r = 0; r < A_R; r++)
      for (int c = 0; c < A_C; c++) check("rst_a_rdata", 64'(a_rdata[r][c]), 64'd0);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_a_rd_cnt", 64'(a_rd_cnt), 64'd0);
    check("rst_a_wr_cnt", 64'(a_wr_cnt), 64'd0);
    check("rst_b_rdata", 64'(b_rdata), 64'd0);
    check("rst_c_rdata", 64'(c_rdata), 64'd0);
    rst_i = 1'b0;
    tick();

    // ---------------- B: latency 3, back-to-back reads ----------------
    for (int i = 0; i < 8; i++) begin
      b_addr  = B_AW'(i);
      b_cs    = '1;
      b_we    = '1;
      b_be    = '1;
      b_wdata = B_DW'(i);
      tick();
    end
    for (int j = 0; j < 13; j++) begin
      if (j < 8) begin
        b_addr = B_AW'(j);
        b_cs   = '1;
        b_we   = '0;
      end else begin
        b_cs = '0;
      end
      tick();
      check("b_b2b_rdata", 64'(b_rdata), (j < 2) ? 64'd0 : ((j > 9) ? 64'd7 : 64'(j - 2)));
    end
    check("b_rd_cnt", 64'(b_rd_cnt), 64'd8);
    check("b_wr_cnt", 64'(b_wr_cnt), 64'd8);
    check("b_err", 64'(b_err), 64'd0);

    // ---------------- C: latency 1, 16-bit words ----------------
    c_addr  = 4'd3;
    c_cs    = '1;
    c_we    = '1;
    c_be    = 2'b11;
    c_wdata = 16'hABCD;
    tick();
    c_wdata = 16'h1200;
    c_be    = 2'b10;
    tick();
    check("c_wr_no_change", 64'(c_rdata), 64'd0);
    c_we = '0;
    tick();
    c_cs = '0;
    check("c_lat1_rdata", 64'(c_rdata), 64'h12CD);
    tick();
    check("c_lat1_hold", 64'(c_rdata), 64'h12CD);
    c_addr  = 4'd4;
    c_cs    = '1;
    c_we    = '1;
    c_be    = 2'b11;
    c_wdata = 16'h5555;
    tick();
    c_we = '0;
    tick();
    c_cs = '0;
    check("c_raw_rdata", 64'(c_rdata), 64'h5555);
    check("c_rd_cnt", 64'(c_rd_cnt), 64'd2);
    check("c_wr_cnt", 64'(c_wr_cnt), 64'd3);
    check("c_err", 64'(c_err), 64'd0);

    // ---------------- A: write then read, latency 2 ----------------
    a_addr     = 8'h10;
    a_cs[0][0] = 1'b1;
    a_we[0][0] = 1'b1;
    a_be[0][0] = 4'hF;
    a_wdata[0] = 32'hDEADBEEF;
    tick();
    a_we[0][0] = 1'b0;
    tick();
    a_idle();
    check("a_lat2_early", 64'(a_rdata[0][0]), 64'd0);
    tick();
    check("a_lat2_data", 64'(a_rdata[0][0]), 64'hDEADBEEF);
    tick();
    tick();
    check("a_lat2_hold", 64'(a_rdata[0][0]), 64'hDEADBEEF);

    // ---------------- A: partial byte enables ----------------
    a_addr     = 8'h20;
    a_cs[0][0] = 1'b1;
    a_we[0][0] = 1'b1;
    a_be[0][0] = 4'hF;
    a_wdata[0] = 32'hFFFFFFFF;
    tick();
    a_wdata[0] = 32'h00000000;
    a_be[0][0] = 4'h5;
    tick();
    a_we[0][0] = 1'b0;
    tick();
    a_idle();
    tick();
    check("a_be_merge", 64'(a_rdata[0][0]), 64'hFF00FF00);
    a_addr     = 8'h21;
    a_cs[0][0] = 1'b1;
    a_we[0][0] = 1'b1;
    a_be[0][0] = 4'hF;
    tick();
    a_idle();
    tick();
    check("a_write_keeps_rdata", 64'(a_rdata[0][0]), 64'hFF00FF00);

    // ---------------- A: multi-row selection ----------------
    a_addr     = 8'h31;
    a_cs[0][0] = 1'b1;
    a_cs[1][1] = 1'b1;
    a_we[0][0] = 1'b1;
    a_we[1][1] = 1'b1;
    a_be[0][0] = 4'hF;
    a_be[1][1] = 4'hF;
    a_wdata[0] = 32'h11112222;
    a_wdata[1] = 32'h33334444;
    tick();
    a_idle();
    check("a_diag_no_err", 64'(a_err), 64'd0);
    a_addr     = 8'h30;
    a_cs[0][1] = 1'b1;
    a_cs[1][1] = 1'b1;
    a_we[0][1] = 1'b1;
    a_we[1][1] = 1'b1;
    a_be[0][1] = 4'hF;
    a_be[1][1] = 4'hF;
    a_wdata[1] = 32'h12345678;
    tick();
    a_idle();
    check("a_multi_err_set", 64'(a_err), 64'd1);
    a_addr     = 8'h30;
    a_cs[0][1] = 1'b1;
    a_cs[1][1] = 1'b1;
    tick();
    a_idle();
    tick();
    check("a_multi_rd01", 64'(a_rdata[0][1]), 64'h12345678);
    check("a_multi_rd11", 64'(a_rdata[1][1]), 64'h12345678);
    check("a_multi_err_sticky", 64'(a_err), 64'd1);
    a_addr     = 8'h31;
    a_cs[0][0] = 1'b1;
    a_cs[1][1] = 1'b1;
    tick();
    a_idle();
    tick();
    check("a_diag_rd00", 64'(a_rdata[0][0]), 64'h11112222);
    check("a_diag_rd11", 64'(a_rdata[1][1]), 64'h33334444);
    check("a_wr_cnt", 64'(a_wr_cnt), 64'd6);
    check("a_rd_cnt", 64'(a_rd_cnt), 64'd4);

    // ---------------- A: reset with a read in flight ----------------
    a_addr     = 8'h10;
    a_cs[0][0] = 1'b1;
    tick();
    a_idle();
    rst_i = 1'b1;
    #1;
    check("a_rst_rdata", 64'(a_rdata[0][0]), 64'd0);
    check("a_rst_err", 64'(a_err), 64'd0);
    check("a_rst_wr_cnt", 64'(a_wr_cnt), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    tick();
    tick();
    check("a_rst_no_late_data", 64'(a_rdata[0][0]), 64'd0);
    a_addr     = 8'h10;
    a_cs[0][0] = 1'b1;
    tick();
    a_idle();
    tick();
    check("a_mem_survives_rst", 64'(a_rdata[0][0]), 64'hDEADBEEF);

    // ---------------- A: counter saturation and clear ----------------
    for (int i = 0; i < 17; i++) begin
      a_addr     = 8'h10;
      a_cs[0][0] = 1'b1;
      a_we[0][0] = 1'b1;
      a_be[0][0] = 4'h0;
      a_wdata[0] = 32'h0;
      tick();
    end
    check("a_wr_cnt_sat", 64'(a_wr_cnt), 64'd15);
    check("a_rd_cnt_pre_clr", 64'(a_rd_cnt), 64'd1);
    a_clr = 1'b1;
    tick();
    a_idle();
    check("a_wr_cnt_clr", 64'(a_wr_cnt), 64'd0);
    check("a_rd_cnt_clr", 64'(a_rd_cnt), 64'd0);
    a_addr     = 8'h10;
    a_cs[0][0] = 1'b1;
    tick();
    a_idle();
    tick();
    check("a_be0_noop", 64'(a_rdata[0][0]), 64'hDEADBEEF);
    check("a_rd_cnt_after_clr", 64'(a_rd_cnt), 64'd1);

    // ---------------- A: randomized run against the model ----------------
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();
    run_random(400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_sram_bank_array.md
# axi_sram_bank_array

Behavioural/synthesizable banked SRAM array with configurable multi-cycle read latency, sitting directly downstream of the AXI SRAM wrapper. It consumes the wrapper's shared bank address, per-bank chip-select, write-enable and byte-enable, and per-column write data. It returns per-bank read data exactly `READ_LATENCY` cycles after a read is presented. It also flags illegal multi-row selection and keeps access counters for performance bring-up.

## Interface
- `SRAM_BANKS_ROWS`, 1, number of bank rows.
- `SRAM_BANKS_COLS`, 1, number of bank columns; the columns together form one AXI data word.
- `SRAM_BANK_ADDR_WIDTH`, 16, word address bits per bank; depth is 2^`SRAM_BANK_ADDR_WIDTH` words.
- `SRAM_BANK_DATA_WIDTH`, 32, bank word width; must be a multiple of 8.
- `SRAM_READ_LATENCY`, 2, read latency in cycles; must be ≥1.
- `CNT_WIDTH`, 32, width of the access counters.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, asynchronous assert, active-high.
- `bank_addr` in `SRAM_BANK_ADDR_WIDTH`: word address, shared by all banks.
- `bank_cs` in [ROWS][COLS]: per-bank chip select.
- `bank_we` in [ROWS][COLS]: per-bank write enable (1 = write); only meaningful when `cs` = 1.
- `bank_be` in [ROWS][COLS][DW/8]: per-bank byte enables for writes.
- `bank_wdata` in [COLS][DW]: write data per column, shared across rows.
- `bank_rdata` out [ROWS][COLS][DW]: per-bank registered read data.
- `err_multi_row_o` out 1: sticky flag for multi-row selection.
- `rd_cnt_o` out `CNT_WIDTH`: count of read cycles.
- `wr_cnt_o` out `CNT_WIDTH`: count of write cycles.
- `cnt_clr_i` in 1: synchronous clear of both counters.

## Operation
- **Storage.** Each bank (r,c) is an independent 2^AW × DW array. Array contents are not reset.
- **Write.** A bank writes when `cs[r][c]` = 1 and `we[r][c]` = 1 at a rising edge.
  - Byte lane b of `mem[r][c][bank_addr]` takes `bank_wdata[c]` byte b iff `be[r][c][b]` = 1.
  - Other bytes keep their value.
  - `be` all-zero is a legal no-op write.
- **Read.** A bank reads when `cs` = 1 and `we` = 0 at a rising edge.
  - It captures `mem[r][c][bank_addr]` into stage 1 of that bank's read pipeline, with a per-bank valid bit.
  - Stages shift every cycle with no stall input.
  - When the valid bit reaches stage `SRAM_READ_LATENCY`, `bank_rdata[r][c]` loads the data.
  - Otherwise `bank_rdata[r][c]` holds its last value. Writes and idle cycles never change it.
- **Read/write ordering.**
  - Read-after-write to the same address one cycle later returns the new data.
  - Pipelined back-to-back reads of different addresses are accepted every cycle.
- **Multi-row error.** If two or more rows have `cs` = 1 in the same column at one edge, `err_multi_row_o` sets.
  - All selected accesses are still performed.
  - The flag stays set until reset.
- **Counters.**
  - `rd_cnt_o` +1 per edge where any bank reads.
  - `wr_cnt_o` +1 per edge where any bank writes. Count is per cycle, not per bank.
  - Both counters saturate at all-ones.
  - `cnt_clr_i` = 1 zeroes both at the edge and has priority over an increment in the same cycle.

## Timing
- **Read latency.** A read presented in cycle k (sampled at the end of k) has its data on `bank_rdata` throughout cycle k+`SRAM_READ_LATENCY`, then held.
  - Latency 1 behaves as a standard synchronous SRAM.
- **Throughput.** One access per bank per cycle. Reads in consecutive cycles appear on consecutive cycles.
- **Reset values.** While `rst_i` is asserted:
  - `bank_rdata` = 0, all pipeline valid bits = 0.
  - `err_multi_row_o` = 0, counters = 0.
- **Reset mid-operation.** Reset asserted with reads in flight drops those reads; no data appears after deassertion.
  - A write sampled at the same edge as reset assertion is not guaranteed.
  - Memory contents survive reset.
- **Counter rules.** Counter increment and saturation are evaluated on the registered value. A counter at max stays at max.

## Test plan
- **Write then read, latency 2.** ROWS=COLS=1. Write 0xDEADBEEF to addr 0x10 with be=0xF, then read addr 0x10 in the next cycle -> `bank_rdata` = 0xDEADBEEF exactly 2 cycles after the read cycle, held while idle.
- **Partial byte enables.** Write 0xFFFFFFFF, then write 0x00000000 with be=0x5, then read -> 0xFF00FF00.
- **Back-to-back reads.** Latency 3, addresses 0..7 preloaded with value = addr, eight reads in consecutive cycles -> `bank_rdata` shows 0..7 on consecutive cycles starting 3 cycles after the first read. `rd_cnt_o` = 8.
- **Multi-row selection.** ROWS=2, COLS=2: `cs[0][1]` and `cs[1][1]` asserted together -> `err_multi_row_o` = 1 from the next cycle and stays 1. Both banks perform the access. `cs[0][0]` with `cs[1][1]` alone does not set the flag.
- **Reset with reads in flight.** Assert `rst_i` one cycle after a read (latency 2) -> `bank_rdata` = 0, and no update after deassertion. A later read of the same address returns the pre-reset data.
- **Counter saturation and clear.** CNT_WIDTH=4, 17 write cycles -> `wr_cnt_o` = 15. `cnt_clr_i` together with a write -> 0.
